// File: rtl/mult_div_unit_if.sv
// Command/result bundle between the multicycle control path and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a_in, b_in, mthi, mtlo, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a_in, b_in, mthi, mtlo, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One radix-2 step per cycle on magnitudes, then a single sign-fix cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clock,
    input logic             reset,
    mult_div_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned DW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [WIDTH-1:0] opnd_q;
    logic [DW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    logic             in_signed_c;
    logic             in_div_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_trial_c;
    logic [DW-1:0]    step_c;
    logic [DW-1:0]    fix_c;
    logic             neg_c;

    // Operand magnitudes; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        in_signed_c = ~bus.op[0];
        in_div_c    = bus.op[1];
        a_mag_c     = (in_signed_c && bus.a_in[WIDTH-1]) ? WIDTH'(-bus.a_in) : bus.a_in;
        b_mag_c     = (in_signed_c && bus.b_in[WIDTH-1]) ? WIDTH'(-bus.b_in) : bus.b_in;
    end

    // acc holds {upper, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
        div_trial_c = acc_q[DW-1:WIDTH-1] - {1'b0, opnd_q};
        step_c      = {mul_sum_c, acc_q[WIDTH-1:1]};
        if (op_q[1]) begin
            if (div_trial_c[WIDTH]) begin
                step_c = {acc_q[DW-2:0], 1'b0};
            end else begin
                step_c = {div_trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Remainder follows the dividend's sign; quotient and product follow sign_a^sign_b.
    always_comb begin
        neg_c = sign_a_q ^ sign_b_q;
        fix_c = neg_c ? DW'(-acc_q) : acc_q;
        if (op_q[1]) begin
            fix_c[DW-1:WIDTH] = sign_a_q ? WIDTH'(-acc_q[DW-1:WIDTH]) : acc_q[DW-1:WIDTH];
            fix_c[WIDTH-1:0]  = neg_c ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    dz_q   <= 1'b0;
                    if (bus.start) begin
                        op_q     <= bus.op;
                        sign_a_q <= in_signed_c & bus.a_in[WIDTH-1];
                        sign_b_q <= in_signed_c & bus.b_in[WIDTH-1];
                        cnt_q    <= '0;
                        if (in_div_c && (bus.b_in == '0)) begin
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            opnd_q  <= in_div_c ? b_mag_c : a_mag_c;
                            acc_q   <= {WIDTH'(0), in_div_c ? a_mag_c : b_mag_c};
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                S_RUN: begin
                    acc_q <= step_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= fix_c[DW-1:WIDTH];
                    lo_q    <= fix_c[WIDTH-1:0];
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    dz_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
